// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass on every write port and an
// integrated per-register busy scoreboard for decode stalls.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 4,
   parameter int unsigned NUM_WR   = 2,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic [NUM_WR-1:0]        set_valid,
   input  logic [NUM_WR*ADDR_W-1:0] set_addr,
   input  logic                     flush
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   // Ascending port order: the last non-blocking write wins, so the highest port has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && !(ZERO_REG && (waddr[j*ADDR_W +: ADDR_W] == '0))) begin
               regs_q[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Clears first, then flush, then sets: a new producer beats both retirement and flush.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (we[j]) begin
            busy_d[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (flush) begin
         busy_d = '0;
      end
      for (int j = 0; j < NUM_WR; j++) begin
         if (set_valid[j]) begin
            busy_d[set_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
      if (ZERO_REG) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              hit;
      logic              zero;

      assign addr = raddr[i*ADDR_W +: ADDR_W];
      assign zero = ZERO_REG && (addr == '0);

      always_comb begin
         data = regs_q[addr];
         hit  = 1'b0;
         for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == addr)) begin
               data = wdata[j*DATA_W +: DATA_W];
               hit  = 1'b1;
            end
         end
         if (zero) begin
            data = '0;
         end
      end

      assign rdata[i*DATA_W +: DATA_W] = data;
      assign rbusy[i] = busy_q[addr] & ~hit & ~zero;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a register/busy model checked every cycle, plus literal
// expectations pinned at each scenario step.
module tb_regfile_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;
   localparam int NW = 2;

   logic             clk;
   logic             rst;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic [NW-1:0]    we;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic [NW-1:0]    set_valid;
   logic [NW*AW-1:0] set_addr;
   logic             flush;

   int checks = 0;
   int errors = 0;

   regfile_mp #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .NUM_RD  (NR),
      .NUM_WR  (NW),
      .ZERO_REG(1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .set_valid(set_valid),
      .set_addr (set_addr),
      .flush    (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural model: register contents and pending-writer flags.
   logic [DW-1:0] m_mem  [32];
   bit            m_busy [32];
   bit            m_valid = 1'b0;

   always @(posedge clk) begin
      bit nb [32];
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            m_mem[r]  <= '0;
            m_busy[r] <= 1'b0;
         end
         m_valid <= 1'b1;
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (we[j] && waddr[j*AW +: AW] != 0) m_mem[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
         end
         for (int r = 1; r < 32; r++) begin
            bit s;
            bit c;
            s = 1'b0;
            c = 1'b0;
            for (int j = 0; j < NW; j++) begin
               if (set_valid[j] && set_addr[j*AW +: AW] == r) s = 1'b1;
               if (we[j] && waddr[j*AW +: AW] == r) c = 1'b1;
            end
            if (s) nb[r] = 1'b1;
            else if (flush || c) nb[r] = 1'b0;
            else nb[r] = m_busy[r];
         end
         nb[0] = 1'b0;
         for (int r = 0; r < 32; r++) m_busy[r] <= nb[r];
      end
   end

   // Expected combinational view of one read port: newest write port first, then storage.
   task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit b);
      bit found;
      found = 1'b0;
      d = '0;
      b = 1'b0;
      if (a != 0) begin
         for (int j = NW - 1; j >= 0; j--) begin
            if (!found && we[j] && waddr[j*AW +: AW] == a) begin
               d = wdata[j*DW +: DW];
               found = 1'b1;
            end
         end
         if (!found) d = m_mem[a];
         b = m_busy[a] && !found;
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < NR; i++) begin
            logic [DW-1:0] ed;
            bit            eb;
            model_read(raddr[i*AW +: AW], ed, eb);
            checks++;
            if (rdata[i*DW +: DW] !== ed || rbusy[i] !== eb) begin
               errors++;
               $display("FAIL model port%0d addr=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                        i, raddr[i*AW +: AW], rdata[i*DW +: DW], rbusy[i], ed, eb);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rst = 1'b0;
      we = '0;
      set_valid = '0;
      flush = 1'b0;
   endtask

   task automatic rd(input int i, input int a);
      raddr[i*AW +: AW] = AW'(a);
   endtask

   function automatic logic [DW-1:0] port_data(input int i);
      return rdata[i*DW +: DW];
   endfunction

   initial begin
      rst = 1'b1;
      raddr = '0;
      we = '0;
      waddr = '0;
      wdata = '0;
      set_valid = '0;
      set_addr = '0;
      flush = 1'b0;

      // Reset, then sweep all addresses across the four ports.
      for (int k = 0; k < 8; k++) begin
         step();
         for (int i = 0; i < NR; i++) rd(i, 4 * k + i);
         #1;
         for (int i = 0; i < NR; i++) begin
            chk("reset_rdata", port_data(i), 32'h0);
            chk("reset_rbusy", {31'b0, rbusy[i]}, 32'h0);
         end
      end

      // Single write with same-cycle bypass, then from storage.
      step();
      we = 2'b01;
      waddr[0 +: AW] = 5'd5;
      wdata[0 +: DW] = 32'hDEADBEEF;
      rd(0, 5);
      #1 chk("bypass_x5", port_data(0), 32'hDEADBEEF);
      step();
      #1 chk("stored_x5", port_data(0), 32'hDEADBEEF);

      // Two ports hit the same register: highest port wins.
      step();
      we = 2'b11;
      waddr = {5'd7, 5'd7};
      wdata = {32'h22222222, 32'h11111111};
      rd(1, 7);
      #1 chk("dual_bypass_x7", port_data(1), 32'h22222222);
      step();
      #1 chk("dual_stored_x7", port_data(1), 32'h22222222);

      // x0 ignores writes and sets.
      step();
      we = 2'b01;
      waddr[0 +: AW] = 5'd0;
      wdata[0 +: DW] = 32'h12345678;
      set_valid = 2'b01;
      set_addr[0 +: AW] = 5'd0;
      rd(2, 0);
      #1 chk("x0_bypass", port_data(2), 32'h0);
      step();
      #1 chk("x0_stored", port_data(2), 32'h0);
      chk("x0_busy", {31'b0, rbusy[2]}, 32'h0);

      // Scoreboard set, clear by writeback, and set+clear in the same cycle.
      step();
      set_valid = 2'b01;
      set_addr[0 +: AW] = 5'd9;
      rd(3, 9);
      #1 chk("x9_busy_before", {31'b0, rbusy[3]}, 32'h0);
      step();
      #1 chk("x9_busy_set", {31'b0, rbusy[3]}, 32'h1);
      step();
      we = 2'b10;
      waddr[AW +: AW] = 5'd9;
      wdata[DW +: DW] = 32'hCAFE0000;
      #1 chk("x9_wb_busy", {31'b0, rbusy[3]}, 32'h0);
      chk("x9_wb_data", port_data(3), 32'hCAFE0000);
      step();
      #1 chk("x9_cleared", {31'b0, rbusy[3]}, 32'h0);
      chk("x9_stored", port_data(3), 32'hCAFE0000);
      step();
      set_valid = 2'b01;
      set_addr[0 +: AW] = 5'd9;
      we = 2'b10;
      waddr[AW +: AW] = 5'd9;
      wdata[DW +: DW] = 32'h0BAD0009;
      #1 chk("x9_setclr_data", port_data(3), 32'h0BAD0009);
      step();
      #1 chk("x9_setclr_busy", {31'b0, rbusy[3]}, 32'h1);

      // Flush clears x3/x4 while a same-cycle set on x10 survives.
      step();
      set_valid = 2'b11;
      set_addr = {5'd4, 5'd3};
      rd(0, 3);
      rd(1, 4);
      rd(2, 10);
      step();
      #1 chk("x3_busy", {31'b0, rbusy[0]}, 32'h1);
      chk("x4_busy", {31'b0, rbusy[1]}, 32'h1);
      step();
      flush = 1'b1;
      set_valid = 2'b10;
      set_addr[AW +: AW] = 5'd10;
      step();
      #1 chk("x3_flushed", {31'b0, rbusy[0]}, 32'h0);
      chk("x4_flushed", {31'b0, rbusy[1]}, 32'h0);
      chk("x10_set_over_flush", {31'b0, rbusy[2]}, 32'h1);

      // Top address with write and set in the same cycle.
      step();
      we = 2'b01;
      waddr[0 +: AW] = 5'd31;
      wdata[0 +: DW] = 32'hA5A5A5A5;
      set_valid = 2'b10;
      set_addr[AW +: AW] = 5'd31;
      rd(3, 31);
      step();
      #1 chk("x31_data", port_data(3), 32'hA5A5A5A5);
      chk("x31_busy", {31'b0, rbusy[3]}, 32'h1);

      // Reset mid-sequence drops the concurrent write/set and clears everything.
      step();
      rst = 1'b1;
      we = 2'b01;
      waddr[0 +: AW] = 5'd12;
      wdata[0 +: DW] = 32'h00000077;
      set_valid = 2'b01;
      set_addr[0 +: AW] = 5'd12;
      step();
      rd(0, 31);
      rd(1, 7);
      rd(2, 9);
      rd(3, 12);
      #1;
      for (int i = 0; i < NR; i++) begin
         chk("post_rst_rdata", port_data(i), 32'h0);
         chk("post_rst_rbusy", {31'b0, rbusy[i]}, 32'h0);
      end
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
